// File: rtl/board_pkg.sv
// Shared types, board geometry and the reset-time board pattern for the
// game-board arbiter.
package board_pkg;

   localparam int ROWS    = 10;
   localparam int COLS    = 10;
   localparam int CELL_W  = 4;
   localparam int COORD_W = 4;

   typedef logic [CELL_W-1:0]  cell_t;
   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXEC    = 2'd1,
      WAIT_VB = 2'd2
   } state_t;

   // Indexed by distance to the nearest board edge: concentric rings.
   localparam logic [4:0][CELL_W-1:0] DEFAULT_LUT = {4'd0, 4'd5, 4'd4, 4'd2, 4'd1};

   function automatic cell_t default_cell(input int r, input int c);
      int d;
      d = r;
      if (c < d) d = c;
      if (ROWS - 1 - r < d) d = ROWS - 1 - r;
      if (COLS - 1 - c < d) d = COLS - 1 - c;
      if (d > 4) d = 4;
      if (d < 0) d = 0;
      return DEFAULT_LUT[3'(d)];
   endfunction

endpackage

// File: rtl/board_arbiter_rr.sv
// Two-requester round-robin picker; the port that was not granted last wins
// a tie. Purely combinational, the last-grant register lives in the caller.
module rr_arbiter2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o,
   output logic       grant_idx_o
);

   always_comb begin
      grant_idx_o = 1'b0;
      if (valid_i == 2'b11) begin
         grant_idx_o = ~last_grant_i;
      end else if (valid_i[1]) begin
         grant_idx_o = 1'b1;
      end
      grant_o = 2'b00;
      if (|valid_i) grant_o[grant_idx_o] = 1'b1;
   end

endmodule

// File: rtl/board_arbiter.sv
// Owns the game board, arbitrates two single-cell read/write requesters and
// optionally holds writes until vertical blanking; video reads bypass the FSM.
module board_arbiter
   import board_pkg::*;
#(
   parameter int ROWS        = board_pkg::ROWS,
   parameter int COLS        = board_pkg::COLS,
   parameter int CELL_W      = board_pkg::CELL_W,
   parameter int SYNC_VBLANK = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   vblank,
   // Handshake: a request transfers on a rising edge where req_valid[n] and
   // req_ready[n] are both high; an un-granted requester holds its fields.
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0]             req_we,
   input  coord_t [1:0]           req_row,
   input  coord_t [1:0]           req_col,
   input  logic [1:0][CELL_W-1:0] req_wdata,
   output logic [1:0]             done,
   output logic                   err,
   output logic [CELL_W-1:0]      rdata,
   input  coord_t                 vid_row,
   input  coord_t                 vid_col,
   output logic [CELL_W-1:0]      vid_cell,
   output logic [1:0]             dbg_state
);

   localparam coord_t ROW_LIM = coord_t'(ROWS);
   localparam coord_t COL_LIM = coord_t'(COLS);

   state_t              state_q, state_d;
   logic                last_grant_q;
   logic                op_we_q;
   logic                op_port_q;
   coord_t              op_row_q, op_col_q;
   logic [CELL_W-1:0]   op_wdata_q;
   logic [1:0]          done_q, done_d;
   logic                err_q, err_d;
   logic [CELL_W-1:0]   rdata_q, rdata_d;
   logic [CELL_W-1:0]   board_q [ROWS][COLS];

   logic [1:0]          grant;
   logic                grant_idx;
   logic                accept;
   logic                commit;
   logic                op_oor;
   logic                vb_ok;

   rr_arbiter2 u_rr (
      .valid_i      (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant),
      .grant_idx_o  (grant_idx)
   );

   assign req_ready = (state_q == IDLE) ? grant : 2'b00;
   assign accept    = |req_ready;
   assign op_oor    = (op_row_q >= ROW_LIM) || (op_col_q >= COL_LIM);
   assign vb_ok     = (SYNC_VBLANK == 0) || vblank;

   always_comb begin
      state_d = state_q;
      done_d  = 2'b00;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = EXEC;
         end
         EXEC: begin
            if (op_oor) begin
               done_d[op_port_q] = 1'b1;
               err_d             = 1'b1;
               rdata_d           = '0;
               state_d           = IDLE;
            end else if (!op_we_q) begin
               rdata_d           = board_q[op_row_q][op_col_q];
               done_d[op_port_q] = 1'b1;
               state_d           = IDLE;
            end else if (vb_ok) begin
               commit            = 1'b1;
               done_d[op_port_q] = 1'b1;
               state_d           = IDLE;
            end else begin
               state_d = WAIT_VB;
            end
         end
         WAIT_VB: begin
            if (vblank) begin
               commit            = 1'b1;
               done_d[op_port_q] = 1'b1;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset reloads the whole board, so a write parked in WAIT_VB is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         op_we_q      <= 1'b0;
         op_port_q    <= 1'b0;
         op_row_q     <= '0;
         op_col_q     <= '0;
         op_wdata_q   <= '0;
         done_q       <= 2'b00;
         err_q        <= 1'b0;
         rdata_q      <= '0;
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               board_q[r][c] <= default_cell(r, c);
            end
         end
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         if (accept) begin
            op_we_q      <= req_we[grant_idx];
            op_port_q    <= grant_idx;
            op_row_q     <= req_row[grant_idx];
            op_col_q     <= req_col[grant_idx];
            op_wdata_q   <= req_wdata[grant_idx];
            last_grant_q <= grant_idx;
         end
         if (commit) board_q[op_row_q][op_col_q] <= op_wdata_q;
      end
   end

   always_comb begin
      vid_cell = '0;
      if ((vid_row < ROW_LIM) && (vid_col < COL_LIM)) vid_cell = board_q[vid_row][vid_col];
   end

   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign dbg_state = state_q;

endmodule
